// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator controller: streams operands MSB first to an
// external 1-bit equality comparator and stops at the first differing bit.
module serial_cmp_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_eq,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  assign bit_a = sa[WIDTH-1];
  assign bit_b = sb[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            cnt   <= CW'(WIDTH - 1);
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // bit_eq is the combinational response to the bits driven this cycle
          if (!bit_eq) begin
            gt    <= bit_a;
            lt    <= ~bit_a;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == '0) begin
            eq    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sa  <= {sa[WIDTH-2:0], 1'b0};
            sb  <= {sb[WIDTH-2:0], 1'b0};
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to compare a and b.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-007 The block SHALL have port bit_a, output, 1 bit: current operand-a bit driven to the external 1-bit equality comparator.
REQ-008 The block SHALL have port bit_b, output, 1 bit: current operand-b bit driven to the external 1-bit equality comparator.
REQ-009 The block SHALL have port bit_eq, input, 1 bit: combinational comparator result, 1 when bit_a == bit_b.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-012 The block SHALL have ports eq, gt, lt, output, 1 bit each: registered result flags for a==b, a>b and a<b.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL load a and b into internal shift registers sa and sb, set the bit counter to WIDTH-1, clear eq/gt/lt and enter SHIFT.
REQ-015 In IDLE with start=0, the block SHALL hold all state.
REQ-016 In every state, bit_a SHALL equal sa[WIDTH-1] and bit_b SHALL equal sb[WIDTH-1] (MSB first); both SHALL be 0 in IDLE after reset.
REQ-017 In SHIFT, the block SHALL sample bit_eq in the same cycle it drives bit_a/bit_b (comparator is combinational).
REQ-018 In SHIFT with bit_eq=0, the block SHALL set gt=bit_a and lt=~bit_a, keep eq=0 and enter DONE (early termination).
REQ-019 In SHIFT with bit_eq=1 and counter=0, the block SHALL set eq=1 and enter DONE.
REQ-020 In SHIFT with bit_eq=1 and counter>0, the block SHALL shift sa and sb left by one (zero fill), decrement the counter and remain in SHIFT.
REQ-021 In DONE, the block SHALL assert done for exactly that one cycle, then enter IDLE unconditionally.
REQ-022 busy SHALL be 1 exactly when the state is SHIFT.
REQ-023 eq, gt and lt SHALL be one-hot after any completed comparison, all 0 while busy, and held in IDLE until the next accepted start.
REQ-024 start SHALL be ignored in SHIFT and DONE, and a and b SHALL be sampled only at the accepted start edge; later operand changes SHALL have no effect.
REQ-025 Latency: with start sampled in cycle n and the first differing bit at index k, done SHALL be high in cycle n+2+(WIDTH-1-k); for equal operands, done SHALL be high in cycle n+1+WIDTH.
REQ-026 A start held high continuously SHALL begin a new comparison in the first IDLE cycle after DONE (back-to-back throughput).
REQ-027 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap below 0.

Reset
REQ-028 Asserting reset SHALL immediately force state to IDLE, and sa, sb, the counter, busy, done, eq, gt, lt, bit_a and bit_b to 0, regardless of clk.
REQ-029 Reset asserted mid-SHIFT SHALL abort the comparison; no done pulse SHALL follow.
REQ-030 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-031 WIDTH=8, a=8'hA5, b=8'hA5, start pulsed -> busy for 8 cycles, then done in cycle n+9 with eq=1, gt=0, lt=0.
REQ-032 WIDTH=8, a=8'h80, b=8'h7F -> mismatch at bit 7; done in cycle n+2 with gt=1, eq=0, lt=0.
REQ-033 WIDTH=8, a=8'h10, b=8'h11 -> mismatch at bit 0; done in cycle n+9 with lt=1; a changed to 8'hFF mid-SHIFT -> result unchanged.
REQ-034 Reset asserted during the fourth SHIFT cycle of an equal compare -> all outputs 0 immediately and no done pulse; then a=3, b=2 -> done with gt=1.
REQ-035 start held high with a=b=0 -> done pulses every WIDTH+2 cycles; start pulses during SHIFT or DONE are ignored.
REQ-036 Exhaustive WIDTH=2 sweep of all 16 {a,b} pairs -> exactly one of eq/gt/lt set per run, matching the unsigned comparison.
